ahb_rr_arbiter: RTL and testbench
=================================

AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, giving the number of masters (legal 2..16).
REQ-002 SHALL have parameter MAX_BEATS, default 16, giving the maximum hready-qualified beats per unlocked tenure (legal 1..256).
REQ-003 SHALL derive MW = ceil(log2(NUM_MASTERS)) for the master-index width.
REQ-004 SHALL have port hclk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port hreset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port hbusreq  input  NUM_MASTERS  per-master bus request.
REQ-007 SHALL have port hlock  input  NUM_MASTERS  per-master locked-transfer request.
REQ-008 SHALL have port hready  input  1  transfer-complete qualifier from the selected slave.
REQ-009 SHALL have port hresp  input  1  slave error response, 1 = ERROR.
REQ-010 SHALL have port hgrant  output  NUM_MASTERS  one-hot grant, or all-zero.
REQ-011 SHALL have port hmaster  output  MW  index of the current owner.
REQ-012 SHALL have port hmastlock  output  1  current tenure is locked.

Function
REQ-013 SHALL implement the states IDLE, OWN, LOCK and ERR, all registered on hclk.
REQ-014 SHALL freeze all state, outputs and the beat counter on any edge where hready=0, except for reset.
REQ-015 SHALL define an arbitration edge as any hready=1 edge in IDLE, any hready=1 edge in OWN where the owner's hbusreq=0, or any hready=1 edge in OWN where beat_cnt=MAX_BEATS-1 and another master requests.
REQ-016 SHALL, at an arbitration edge, grant the first requester found by searching from (last_owner+1) mod NUM_MASTERS upward with wrap-around.
REQ-017 SHALL re-grant the current owner if it is the only requester at an arbitration edge.
REQ-018 SHALL update hgrant and hmaster on the arbitration edge itself, giving one-cycle latency from a sampled request to the grant.
REQ-019 SHALL enter IDLE with hgrant=0 when no master requests at an arbitration edge (ARB_PARK_EN undefined).
REQ-020 SHALL hold hmaster at the last owner while in IDLE.
REQ-021 SHALL enter OWN, clear beat_cnt and advance last_owner when a grant is issued without hlock.
REQ-022 SHALL enter LOCK when the granted master's hlock=1 at the grant edge, or when the owner's hlock=1 on any hready=1 edge in OWN.
REQ-023 SHALL, in OWN, increment beat_cnt on each hready=1 edge, saturating at MAX_BEATS-1.
REQ-024 SHALL, in LOCK, drive hmastlock=1, ignore beat_cnt and perform no re-arbitration.
REQ-025 SHALL exit LOCK through an arbitration edge on the first hready=1 edge where the owner's hlock=0.
REQ-026 SHALL, on any hready=1 edge in OWN or LOCK with hresp=1, go to ERR, clear hgrant and clear hmastlock.
REQ-027 SHALL keep last_owner equal to the erroring master so that the next search starts after it.
REQ-028 SHALL leave ERR for IDLE after exactly one hready=1 cycle.
REQ-029 SHALL give hresp=1 priority over lock hold, MAX_BEATS expiry and request changes when they occur on the same edge.
REQ-030 SHALL ignore hresp in IDLE and ERR.
REQ-031 SHALL never assert more than one hgrant bit.

Reset
REQ-032 SHALL, while hreset=1, drive hgrant=0, hmaster=0, hmastlock=0, state=IDLE, beat_cnt=0 and last_owner=NUM_MASTERS-1, so that master 0 has first priority.
REQ-033 SHALL, on hreset asserted mid-tenure (including LOCK), clear all state immediately without waiting for a clock edge.
REQ-034 SHALL allow the first arbitration on the first hready=1 edge after reset deassertion.

Configuration
REQ-035 SHALL, with ARB_PARK_EN defined, assert hgrant[0] and drive hmaster=0 in IDLE (default-master parking), with hmastlock=0 and last_owner unchanged.
REQ-036 SHALL, with ARB_PARK_EN defined, make reset drive hgrant=1 (hgrant[0] asserted).
REQ-037 SHALL, with ARB_PARK_EN undefined, drive hgrant=0 in IDLE.

Verification
REQ-038 SHALL cover: NUM_MASTERS=4, hready=1, hbusreq=4'b1111 held -> grants 0,1,2,3,0 at MAX_BEATS-beat intervals.
REQ-039 SHALL cover: only master 2 requests for 40 cycles with MAX_BEATS=16 -> hgrant=4'b0100 continuously, with no gap.
REQ-040 SHALL cover: master 1 asserts hlock with all masters requesting for 30 beats -> hmastlock=1 and hmaster=1 throughout, then the grant passes to master 2 one edge after hlock drops.
REQ-041 SHALL cover: hresp=1 with hready=1 while master 3 owns -> hgrant=0 the next cycle, ERR for one cycle, then master 0 is granted.
REQ-042 SHALL cover: hready=0 for 5 cycles with a new request pending -> no change to hgrant or hmaster, and arbitration resolves on the first hready=1 edge.
REQ-043 SHALL cover: hreset pulsed mid-LOCK -> all outputs 0 asynchronously, and with ARB_PARK_EN defined hgrant=4'b0001 after reset.

Source files
------------

// File: rtl/ahb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_rr_arbiter
// Brief    : Round-robin AHB bus arbiter with locked tenures, beat-limited
//            unlocked tenures and an error-recovery state. The optional
//            default-master parking feature is enabled with ARB_PARK_EN.
// Revision : 1.0
// ============================================================================
module ahb_rr_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int MAX_BEATS   = 16,
   localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                   hclk,
   input  logic                   hreset,
   input  logic [NUM_MASTERS-1:0] hbusreq,
   input  logic [NUM_MASTERS-1:0] hlock,
   input  logic                   hready,
   input  logic                   hresp,
   output logic [NUM_MASTERS-1:0] hgrant,
   output logic [MW-1:0]          hmaster,
   output logic                   hmastlock
);

   localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BEATS - 1);
   localparam logic [MW-1:0] LAST_INIT = MW'(NUM_MASTERS - 1);
`ifdef ARB_PARK_EN
   localparam logic [NUM_MASTERS-1:0] IDLE_GRANT = NUM_MASTERS'(1);
   localparam logic                   PARK       = 1'b1;
`else
   localparam logic [NUM_MASTERS-1:0] IDLE_GRANT = '0;
   localparam logic                   PARK       = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      LOCK = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t                 state;
   logic [BW-1:0]          beat_cnt;
   logic [MW-1:0]          last_owner;
   logic [MW-1:0]          arb_idx;
   logic [MW-1:0]          cand;
   logic                   arb_found;
   logic                   others_req;
   logic                   arb_edge;
   logic [NUM_MASTERS-1:0] owner_oh;
   logic [NUM_MASTERS-1:0] arb_oh;

   // Scan farthest-to-nearest so the last hit is the first requester after last_owner.
   always_comb begin
      int sum;
      sum       = 0;
      arb_found = 1'b0;
      arb_idx   = last_owner;
      cand      = last_owner;
      for (int i = NUM_MASTERS; i >= 1; i--) begin
         sum = int'(last_owner) + i;
         if (sum >= NUM_MASTERS) begin
            sum = sum - NUM_MASTERS;
         end
         cand = MW'(sum);
         if (hbusreq[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   always_comb begin
      owner_oh             = '0;
      owner_oh[last_owner] = 1'b1;
      arb_oh               = '0;
      arb_oh[arb_idx]      = 1'b1;
      others_req           = |(hbusreq & ~owner_oh);
      arb_edge = (state == IDLE)
              || (state == OWN  && !hresp && !hlock[last_owner]
                  && (!hbusreq[last_owner] || (beat_cnt == BEAT_LAST && others_req)))
              || (state == LOCK && !hresp && !hlock[last_owner]);
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state      <= IDLE;
         hgrant     <= IDLE_GRANT;
         hmaster    <= '0;
         hmastlock  <= 1'b0;
         beat_cnt   <= '0;
         last_owner <= LAST_INIT;
      end else if (hready) begin
         if ((state == OWN || state == LOCK) && hresp) begin
            // last_owner stays on the erroring master so the next search skips it
            state     <= ERR;
            hgrant    <= '0;
            hmastlock <= 1'b0;
         end else if (arb_edge) begin
            if (arb_found) begin
               hgrant     <= arb_oh;
               hmaster    <= arb_idx;
               last_owner <= arb_idx;
               beat_cnt   <= '0;
               if (hlock[arb_idx]) begin
                  state     <= LOCK;
                  hmastlock <= 1'b1;
               end else begin
                  state     <= OWN;
                  hmastlock <= 1'b0;
               end
            end else begin
               state     <= IDLE;
               hgrant    <= IDLE_GRANT;
               hmastlock <= 1'b0;
               if (PARK) begin
                  hmaster <= '0;
               end
            end
         end else begin
            case (state)
               OWN: begin
                  if (hlock[last_owner]) begin
                     state     <= LOCK;
                     hmastlock <= 1'b1;
                  end else if (beat_cnt != BEAT_LAST) begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
               ERR: begin
                  state  <= IDLE;
                  hgrant <= IDLE_GRANT;
                  if (PARK) begin
                     hmaster <= '0;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ahb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_rr_arbiter
// Brief    : Self-checking bench for ahb_rr_arbiter: tenure-level reference
//            model compared every cycle plus directed literal expectations.
// Revision : 1.0
// ============================================================================
module tb_ahb_rr_arbiter;

   localparam int NM   = 4;
   localparam int MAXB = 16;
   localparam int MW   = 2;
`ifdef ARB_PARK_EN
   localparam bit PARK = 1'b1;
`else
   localparam bit PARK = 1'b0;
`endif
   localparam logic [31:0] IDLE_G = PARK ? 32'd1 : 32'd0;

   logic          hclk    = 1'b0;
   logic          hreset  = 1'b1;
   logic [NM-1:0] hbusreq = '0;
   logic [NM-1:0] hlock   = '0;
   logic          hready  = 1'b1;
   logic          hresp   = 1'b0;
   logic [NM-1:0] hgrant;
   logic [MW-1:0] hmaster;
   logic          hmastlock;

   int n_tests = 0;
   int n_fail  = 0;

   ahb_rr_arbiter #(.NUM_MASTERS(NM), .MAX_BEATS(MAXB)) dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .hbusreq   (hbusreq),
      .hlock     (hlock),
      .hready    (hready),
      .hresp     (hresp),
      .hgrant    (hgrant),
      .hmaster   (hmaster),
      .hmastlock (hmastlock)
   );

   always #5 hclk = ~hclk;

   function automatic bit bit_of(input logic [NM-1:0] v, input int i);
      logic [NM-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   // Tenure-level model: who owns the bus, for how many beats, locked or not.
   int m_owner = -1;
   int m_last  = NM - 1;
   int m_hm    = 0;
   int m_beats = 0;
   int m_c     = 0;
   bit m_lock  = 1'b0;
   bit m_err   = 1'b0;
   bit m_found = 1'b0;

   always @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         m_owner = -1; m_last = NM - 1; m_hm = 0; m_beats = 0; m_lock = 0; m_err = 0;
      end else if (hready) begin
         if (m_owner >= 0 && hresp) begin
            m_err = 1; m_owner = -1; m_lock = 0;
         end else if (m_err) begin
            m_err = 0;
         end else if (m_owner >= 0 && !m_lock && bit_of(hlock, m_owner)) begin
            m_lock = 1;
         end else if (m_owner < 0 || (m_lock && !bit_of(hlock, m_owner)) ||
                      (!m_lock && (!bit_of(hbusreq, m_owner) ||
                       (m_beats >= MAXB - 1 && (hbusreq & ~(NM'(1) << m_owner)) != '0)))) begin
            m_found = 0;
            for (int k = 1; k <= NM; k++) begin
               m_c = (m_last + k) % NM;
               if (!m_found && bit_of(hbusreq, m_c)) begin
                  m_found = 1; m_owner = m_c; m_last = m_c; m_hm = m_c;
                  m_beats = 0; m_lock = bit_of(hlock, m_c);
               end
            end
            if (!m_found) begin
               m_owner = -1; m_lock = 0;
            end
         end else begin
            m_beats++;
         end
      end
   end

   logic [NM-1:0] eg;
   logic [MW-1:0] em;
   logic          el;

   always @(negedge hclk) begin
      eg = '0; em = MW'(m_hm); el = 1'b0;
      if (m_owner >= 0) begin
         eg = NM'(1) << m_owner; em = MW'(m_owner); el = m_lock;
      end else if (PARK && !m_err) begin
         eg = NM'(1); em = '0;
      end
      n_tests++;
      if (hgrant !== eg || hmaster !== em || hmastlock !== el || $countones(hgrant) > 1) begin
         n_fail++;
         $display("FAIL model t=%0t hgrant=%b want %b hmaster=%0d want %0d hmastlock=%b want %b",
                  $time, hgrant, eg, hmaster, em, hmastlock, el);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge hclk);
      #1;
   endtask

   initial begin
      tick(2);
      check("reset_hgrant", 32'(hgrant), IDLE_G);
      check("reset_hmaster", 32'(hmaster), 32'd0);
      check("reset_hmastlock", 32'(hmastlock), 32'd0);
      hreset = 1'b0;
      tick(1);
      check("idle_no_req", 32'(hgrant), IDLE_G);

      // All four request continuously: 0,1,2,3,0 every MAX_BEATS edges
      hbusreq = 4'b1111;
      tick(1);
      check("rr_first", 32'(hgrant), 32'd1);
      for (int m = 1; m <= 4; m++) begin
         tick(MAXB - 1);
         check("rr_hold", 32'(hgrant), 32'd1 << ((m - 1) % 4));
         tick(1);
         check("rr_next", 32'(hgrant), 32'd1 << (m % 4));
      end

      // Sole requester keeps the bus with no gap
      hbusreq = 4'b0100;
      tick(1);
      check("solo_grant", 32'(hgrant), 32'h4);
      for (int c = 0; c < 40; c++) begin
         tick(1);
         check("solo_hold", 32'(hgrant), 32'h4);
      end
      hbusreq = 4'b0000;
      tick(1);
      check("idle_grant", 32'(hgrant), IDLE_G);
      check("idle_hmaster", 32'(hmaster), PARK ? 32'd0 : 32'd2);

      // Locked tenure for master 1
      hbusreq = 4'b0010;
      hlock   = 4'b0010;
      tick(1);
      check("lock_grant", 32'(hgrant), 32'h2);
      check("lock_mastlock", 32'(hmastlock), 32'd1);
      hbusreq = 4'b1111;
      for (int c = 0; c < 30; c++) begin
         tick(1);
         check("lock_hold", 32'({hmastlock, hmaster}), 32'h5);
      end
      hlock = 4'b0000;
      tick(1);
      check("unlock_grant", 32'(hgrant), 32'h4);
      check("unlock_mastlock", 32'(hmastlock), 32'd0);

      // Error while master 3 owns
      hbusreq = 4'b1000;
      tick(1);
      check("own3_grant", 32'(hgrant), 32'h8);
      hbusreq = 4'b1111;
      hresp   = 1'b1;
      tick(1);
      check("err_grant", 32'(hgrant), 32'h0);
      check("err_mastlock", 32'(hmastlock), 32'd0);
      tick(1);
      check("err_to_idle", 32'(hgrant), IDLE_G);
      tick(1);
      check("after_err_grant", 32'({hgrant, hmaster}), 32'h04);
      hresp = 1'b0;

      // hready low freezes arbitration with a new request pending
      hbusreq = 4'b0010;
      hready  = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick(1);
         check("stall_hold", 32'({hgrant, hmaster}), 32'h04);
      end
      hready = 1'b1;
      tick(1);
      check("stall_release", 32'({hgrant, hmaster}), 32'h09);

      // Asynchronous reset in the middle of a locked tenure
      hlock = 4'b0010;
      tick(1);
      check("prereset_lock", 32'(hmastlock), 32'd1);
      #3;
      hreset = 1'b1;
      #1;
      check("async_hgrant", 32'(hgrant), IDLE_G);
      check("async_hmaster", 32'(hmaster), 32'd0);
      check("async_hmastlock", 32'(hmastlock), 32'd0);
      hlock   = 4'b0000;
      hbusreq = 4'b0011;
      tick(2);
      hreset = 1'b0;
      tick(1);
      check("post_reset_m0", 32'(hgrant), 32'h1);
      hbusreq = 4'b0010;
      tick(1);
      check("post_reset_m1", 32'(hgrant), 32'h2);
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
